fabric_cfg_loader: RTL and testbench
====================================

FABRIC_CFG_LOADER -- requirements
Module: fabric_cfg_loader

Interface
REQ-001 SHALL have parameter COLS, default 8: tile columns in the array.
REQ-002 SHALL have parameter ROWS, default 8: tile rows in the array.
REQ-003 SHALL have parameter CLB_BITS, default 32: CLB chain bits per tile.
REQ-004 SHALL have parameter CONN_BITS, default 64: interconnect (CB/SB) chain bits per tile.
REQ-005 SHALL have parameter WORD_W, default 32: config word width.
REQ-006 Derived: CLB_LEN=COLS*ROWS*CLB_BITS; CONN_LEN=COLS*ROWS*CONN_BITS; NW_CLB=ceil(CLB_LEN/WORD_W); NW_CONN=ceil(CONN_LEN/WORD_W).
REQ-007 Ports SHALL be:
 clk  in  1  single system clock; all logic on posedge.
 rst  in  1  synchronous, active-high reset.
 start  in  1  single-cycle load request.
 cfg_data  in  WORD_W  config word, LSB shifted first.
 cfg_valid  in  1  cfg_data valid.
 cfg_ready  out  1  loader accepts word this cycle.
 busy  out  1  load in progress.
 done  out  1  one-cycle completion pulse.
 err  out  1  sticky CRC mismatch flag.
 scan_clk  out  1  scan shift strobe to fabric.
 clb_scan_in  out  1  serial data into CLB chain.
 clb_scan_en  out  1  CLB chain shift enable.
 conn_scan_in  out  1  serial data into interconnect chain.
 conn_scan_en  out  1  interconnect chain shift enable.

Function
REQ-008 SHALL implement FSM states IDLE, CLB_WAIT, CLB_SHIFT, CONN_WAIT, CONN_SHIFT, CRC_WAIT (CFG_CRC_EN only), FINISH.
REQ-009 IDLE: start=1 -> CLB_WAIT, busy=1 next cycle; start while busy SHALL be ignored.
REQ-010 cfg_ready SHALL be 1 only in *_WAIT states; word accepted on cfg_valid&&cfg_ready; cfg_valid outside *_WAIT SHALL be ignored.
REQ-011 Accept in CLB_WAIT/CONN_WAIT -> word latched, state to matching *_SHIFT next cycle.
REQ-012 Each bit SHALL take 2 clk: phase A data on *_scan_in, scan_clk=0; phase B same data, scan_clk=1.
REQ-013 Bits per word SHALL be WORD_W, except last word of a chain: CLB_LEN-(NW_CLB-1)*WORD_W (resp. CONN); upper bits discarded.
REQ-014 After a word's last phase B: return to *_WAIT if chain words remain; else CLB->CONN_WAIT, CONN->CRC_WAIT (CRC_EN) or FINISH.
REQ-015 clb_scan_en SHALL be 1 throughout CLB_WAIT/CLB_SHIFT; conn_scan_en throughout CONN_WAIT/CONN_SHIFT; never both.
REQ-016 scan_clk SHALL be 0 in all states other than phase B; no scan_clk pulse while waiting for a word.
REQ-017 Idle *_scan_in SHALL be 0.
REQ-018 FINISH: done=1 for one cycle, busy=0 next cycle, -> IDLE.
REQ-019 err SHALL clear on accepted start; holds otherwise.
REQ-020 Bit/word counters SHALL be sized $clog2(max+1); no wrap within a load.

Reset
REQ-021 rst=1 SHALL force IDLE; cfg_ready, busy, done, scan_clk, clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in = 0; err=0; counters cleared.
REQ-022 rst mid-load SHALL abort; partial chain contents are undefined; next start restarts from CLB bit 0.
REQ-023 rst has priority over start in same cycle.

Configuration
REQ-024 Macro CFG_CRC_EN: when defined, CRC-8 (poly 0x07, init 0x00, MSB-first register, fed every shifted bit in shift order, CLB then CONN) SHALL be kept; CRC_WAIT accepts one extra word whose [7:0] is compared; mismatch sets err in FINISH cycle with done.
REQ-025 Without CFG_CRC_EN: no CRC logic, no CRC_WAIT, err tied 0.

Verification (COLS=2 ROWS=1 CLB_BITS=20 CONN_BITS=12 WORD_W=32: CLB_LEN=40, CONN_LEN=24)
REQ-026 Start, words 0xA5A5A5A5, 0x000000FF, 0x00ABCDEF, valid always -> 40 clb pulses then 24 conn pulses, serial streams match LSB-first, done 1 cycle, busy low after.
REQ-027 cfg_valid withheld 10 cycles between CLB words -> clb_scan_en stays 1, zero scan_clk pulses in gap, data intact.
REQ-028 Last CLB word 0xFFFFFF00 -> only 8 bits (all 0) shifted; upper 24 bits never appear on clb_scan_in.
REQ-029 rst asserted after 17th CLB bit -> next cycle all outputs 0; new start reloads 40+24 bits correctly.
REQ-030 CFG_CRC_EN, correct CRC word then CRC^0x01 -> first load err=0, second err=1 with done; third start clears err.
REQ-031 start pulsed during CONN_SHIFT and cfg_valid=1 in IDLE -> no effect, no extra pulses, cfg_ready stays 0 in IDLE.

Source files
------------

// File: rtl/fabric_cfg_loader.sv
// Streams config words LSB-first into the CLB scan chain, then the interconnect scan chain.
// Define CFG_CRC_EN to add a CRC-8 check of the shifted stream against a trailing CRC word.
module fabric_cfg_loader #(
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter int CLB_BITS  = 32,
    parameter int CONN_BITS = 64,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              scan_clk,
    output logic              clb_scan_in,
    output logic              clb_scan_en,
    output logic              conn_scan_in,
    output logic              conn_scan_en
);

    localparam int CLB_LEN   = COLS * ROWS * CLB_BITS;
    localparam int CONN_LEN  = COLS * ROWS * CONN_BITS;
    localparam int NW_CLB    = (CLB_LEN + WORD_W - 1) / WORD_W;
    localparam int NW_CONN   = (CONN_LEN + WORD_W - 1) / WORD_W;
    localparam int CLB_LAST  = CLB_LEN - (NW_CLB - 1) * WORD_W;
    localparam int CONN_LAST = CONN_LEN - (NW_CONN - 1) * WORD_W;
    localparam int NW_MAX    = (NW_CLB > NW_CONN) ? NW_CLB : NW_CONN;
    localparam int BIT_W     = $clog2(WORD_W + 1);
    localparam int WCNT_W    = $clog2(NW_MAX + 1);

    localparam logic [BIT_W-1:0]  CLB_LAST_BIT   = BIT_W'(CLB_LAST - 1);
    localparam logic [BIT_W-1:0]  CONN_LAST_BIT  = BIT_W'(CONN_LAST - 1);
    localparam logic [BIT_W-1:0]  FULL_LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] CLB_LAST_WORD  = WCNT_W'(NW_CLB - 1);
    localparam logic [WCNT_W-1:0] CONN_LAST_WORD = WCNT_W'(NW_CONN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLB_WAIT,
        CLB_SHIFT,
        CONN_WAIT,
        CONN_SHIFT,
`ifdef CFG_CRC_EN
        CRC_WAIT,
`endif
        FINISH
    } state_t;

`ifdef CFG_CRC_EN
    localparam state_t AFTER_CONN = CRC_WAIT;
`else
    localparam state_t AFTER_CONN = FINISH;
`endif

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                phase_q, phase_d;

    logic                in_clb;
    logic                in_conn;
    logic                in_shift;
    logic                word_last;
    logic [BIT_W-1:0]    bit_limit;
    logic                word_end;

    // Chain decode; the word/bit limits select the short tail word of each chain.
    always_comb begin
        in_clb    = (state_q == CLB_WAIT) || (state_q == CLB_SHIFT);
        in_conn   = (state_q == CONN_WAIT) || (state_q == CONN_SHIFT);
        in_shift  = (state_q == CLB_SHIFT) || (state_q == CONN_SHIFT);
        word_last = in_clb ? (wcnt_q == CLB_LAST_WORD) : (wcnt_q == CONN_LAST_WORD);
        if (word_last) begin
            bit_limit = in_clb ? CLB_LAST_BIT : CONN_LAST_BIT;
        end else begin
            bit_limit = FULL_LAST_BIT;
        end
        word_end = in_shift && phase_q && (bit_q == bit_limit);
    end

    always_comb begin
        cfg_ready    = (state_q == CLB_WAIT) || (state_q == CONN_WAIT);
`ifdef CFG_CRC_EN
        cfg_ready    = cfg_ready || (state_q == CRC_WAIT);
`endif
        busy         = (state_q != IDLE);
        done         = (state_q == FINISH);
        scan_clk     = in_shift && phase_q;
        clb_scan_en  = in_clb;
        conn_scan_en = in_conn;
        clb_scan_in  = (state_q == CLB_SHIFT) && word_q[0];
        conn_scan_in = (state_q == CONN_SHIFT) && word_q[0];
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLB_WAIT;
                    wcnt_d  = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            CLB_WAIT, CONN_WAIT: begin
                if (cfg_valid) begin
                    word_d  = cfg_data;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = (state_q == CLB_WAIT) ? CLB_SHIFT : CONN_SHIFT;
                end
            end
            CLB_SHIFT, CONN_SHIFT: begin
                phase_d = ~phase_q;
                // Advance to the next bit only after the strobe-high phase.
                if (phase_q) begin
                    word_d = word_q >> 1;
                    if (word_end) begin
                        bit_d = '0;
                        if (!word_last) begin
                            wcnt_d  = wcnt_q + 1'b1;
                            state_d = in_clb ? CLB_WAIT : CONN_WAIT;
                        end else begin
                            wcnt_d  = '0;
                            state_d = in_clb ? CONN_WAIT : AFTER_CONN;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef CFG_CRC_EN
            CRC_WAIT: begin
                if (cfg_valid) begin
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            wcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
        end
    end

`ifdef CFG_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       err_q, err_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // The CRC sees each bit once, on its strobe-high phase, in shift order.
    always_comb begin
        crc_d = crc_q;
        err_d = err_q;
        if ((state_q == IDLE) && start) begin
            crc_d = '0;
            err_d = 1'b0;
        end else if (in_shift && phase_q) begin
            crc_d = crc8_step(crc_q, word_q[0]);
        end else if ((state_q == CRC_WAIT) && cfg_valid) begin
            err_d = err_q | (cfg_data[7:0] != crc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader with COLS=2 ROWS=1 CLB_BITS=20 CONN_BITS=12 WORD_W=32.
// CRC scenarios are included when CFG_CRC_EN is defined.
module tb_fabric_cfg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        scan_clk;
    logic        clb_scan_in;
    logic        clb_scan_en;
    logic        conn_scan_in;
    logic        conn_scan_en;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [63:0] clb_vec;
    logic [63:0] conn_vec;
    int          clb_n;
    int          conn_n;
    int          done_n;
    int          viol;
    logic        prev_sclk;
    logic        prev_clb_in;
    logic        prev_conn_in;

    fabric_cfg_loader #(
        .COLS      (2),
        .ROWS      (1),
        .CLB_BITS  (20),
        .CONN_BITS (12),
        .WORD_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .scan_clk     (scan_clk),
        .clb_scan_in  (clb_scan_in),
        .clb_scan_en  (clb_scan_en),
        .conn_scan_in (conn_scan_in),
        .conn_scan_en (conn_scan_en)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stream capture and protocol watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (clb_scan_en && conn_scan_en) viol++;
            if (scan_clk && cfg_ready) viol++;
            if (scan_clk && !(clb_scan_en || conn_scan_en)) viol++;
            if (!clb_scan_en && clb_scan_in) viol++;
            if (!conn_scan_en && conn_scan_in) viol++;
            if (cfg_ready && !busy) viol++;
            if (scan_clk) begin
                if (prev_sclk) viol++;
                if (clb_scan_en) begin
                    if (prev_clb_in !== clb_scan_in) viol++;
                    if (clb_n < 64) clb_vec[clb_n] = clb_scan_in;
                    clb_n++;
                end
                if (conn_scan_en) begin
                    if (prev_conn_in !== conn_scan_in) viol++;
                    if (conn_n < 64) conn_vec[conn_n] = conn_scan_in;
                    conn_n++;
                end
            end
            if (done) done_n++;
        end
        prev_sclk    = scan_clk;
        prev_clb_in  = clb_scan_in;
        prev_conn_in = conn_scan_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clb_vec  = '0;
        conn_vec = '0;
        clb_n    = 0;
        conn_n   = 0;
        done_n   = 0;
        viol     = 0;
    endtask

`ifdef CFG_CRC_EN
    function automatic logic [7:0] crc_ref(input logic [39:0] c, input logic [23:0] k);
        logic [7:0] r;
        logic       b;
        r = 8'h00;
        for (int i = 0; i < 64; i++) begin
            if (i < 40) b = c[i];
            else        b = k[i-40];
            if (r[7] ^ b) r = {r[6:0], 1'b0} ^ 8'h07;
            else          r = {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Presents a word and returns at the falling edge after it was accepted.
    task automatic send_word(input string tag, input logic [31:0] w);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, (n < 300), 1'b1);
        @(negedge clk);
    endtask

    task automatic run_load(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [39:0] exp_clb,
                            input logic [23:0] exp_conn, input int gap, input bit mid_start,
                            input logic [7:0] crc_xor, input logic exp_err);
        int n;
        int p;
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1'b1);
        chk({tag, "_err_clear"}, err, 1'b0);
        send_word({tag, "_w0"}, w0);
        if (gap > 0) begin
            cfg_valid = 1'b0;
            n = 0;
            while (cfg_ready !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_gap_wait"}, (n < 300), 1'b1);
            p = clb_n;
            repeat (gap) @(negedge clk);
            chk({tag, "_gap_pulses"}, clb_n - p, 0);
            chk({tag, "_gap_en"}, {clb_scan_en, cfg_ready, conn_scan_en}, 3'b110);
        end
        send_word({tag, "_w1"}, w1);
        send_word({tag, "_w2"}, w2);
        if (mid_start) begin
            start = 1'b1;
            chk({tag, "_in_conn"}, conn_scan_en, 1'b1);
            @(negedge clk);
            start = 1'b0;
        end
`ifdef CFG_CRC_EN
        send_word({tag, "_crc"}, {24'h0, crc_ref(exp_clb, exp_conn) ^ crc_xor});
`else
        if (crc_xor != 8'h00) $display("note: CRC word skipped in this build");
`endif
        cfg_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_err_at_done"}, err, exp_err);
        @(negedge clk);
        chk({tag, "_after_done"}, {done, busy}, 2'b00);
        repeat (3) @(negedge clk);
        chk({tag, "_err_hold"}, err, exp_err);
        chk({tag, "_clb_pulses"}, clb_n, 40);
        chk({tag, "_conn_pulses"}, conn_n, 24);
        chk({tag, "_clb_stream"}, clb_vec[39:0], exp_clb);
        chk({tag, "_conn_stream"}, conn_vec[23:0], exp_conn);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_protocol"}, viol, 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {cfg_ready, busy, done, scan_clk, clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in, err},
            9'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {cfg_ready, busy, done, scan_clk}, 4'b0);

        run_load("basic", 32'hA5A5A5A5, 32'h000000FF, 32'h00ABCDEF,
                 40'hFF_A5A5A5A5, 24'hABCDEF, 0, 1'b0, 8'h00, 1'b0);

        run_load("gap", 32'h12345678, 32'h0000005A, 32'h00F0F00F,
                 40'h5A_12345678, 24'hF0F00F, 10, 1'b0, 8'h00, 1'b0);

        run_load("tail", 32'hDEADBEEF, 32'hFFFFFF00, 32'hFF123456,
                 40'h00_DEADBEEF, 24'h123456, 0, 1'b0, 8'h00, 1'b0);

        // Abort a load after the 17th CLB bit.
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word("abort_w0", 32'hA5A5A5A5);
        n = 0;
        while (clb_n < 17 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach17", (n < 300), 1'b1);
        rst = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("abort_outputs",
            {cfg_ready, busy, done, scan_clk, clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in, err},
            9'b0);
        rst = 1'b0;
        @(negedge clk);
        run_load("reload", 32'h0F0F3C3C, 32'h000000A6, 32'h00112233,
                 40'hA6_0F0F3C3C, 24'h112233, 0, 1'b0, 8'h00, 1'b0);

        run_load("midstart", 32'hCAFEF00D, 32'h00000081, 32'h00800001,
                 40'h81_CAFEF00D, 24'h800001, 0, 1'b1, 8'h00, 1'b0);

        // Valid words offered while idle must be ignored.
        clear_mon();
        cfg_data  = 32'h00000001;
        cfg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", cfg_ready, 1'b0);
        end
        cfg_valid = 1'b0;
        chk("idle_state", {busy, clb_scan_en, conn_scan_en}, 3'b000);
        chk("idle_pulses", clb_n + conn_n, 0);

`ifdef CFG_CRC_EN
        run_load("crc_ok", 32'hA5A5A5A5, 32'h000000FF, 32'h00ABCDEF,
                 40'hFF_A5A5A5A5, 24'hABCDEF, 0, 1'b0, 8'h00, 1'b0);
        run_load("crc_bad", 32'hA5A5A5A5, 32'h000000FF, 32'h00ABCDEF,
                 40'hFF_A5A5A5A5, 24'hABCDEF, 0, 1'b0, 8'h01, 1'b1);
        run_load("crc_clear", 32'hA5A5A5A5, 32'h000000FF, 32'h00ABCDEF,
                 40'hFF_A5A5A5A5, 24'hABCDEF, 0, 1'b0, 8'h00, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
